block_swap_sequencer: RTL

BLOCK_SWAP_SEQUENCER -- requirements
Module: block_swap_sequencer

---
 rtl/block_swap_sequencer_if.sv | 43 ++++
 rtl/block_swap_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/block_swap_sequencer_if.sv
// Swap-request, SRAM port and backing-memory port bundle for the block swap sequencer.
// master is the sequencer side, slave is the environment (blocker, SRAM, memory).
interface block_swap_sequencer_if #(
  parameter int unsigned BlockWords = 16,
  parameter int unsigned NumSlots   = 4
);
  localparam int unsigned SlotW  = $clog2(NumSlots);
  localparam int unsigned WordW  = $clog2(BlockWords);
  localparam int unsigned SramAw = SlotW + WordW;

  logic              swap_req_i;
  logic [SlotW-1:0]  old_addr_idx_i;
  logic [20:0]       old_addr_i;
  logic [20:0]       new_addr_i;
  logic              done_o;
  logic              busy_o;
  logic              sram_req_o;
  logic              sram_we_o;
  logic [SramAw-1:0] sram_addr_o;
  logic [31:0]       sram_wdata_o;
  logic [31:0]       sram_rdata_i;
  logic              ext_req_o;
  logic              ext_we_o;
  logic [31:0]       ext_addr_o;
  logic [31:0]       ext_wdata_o;
  logic              ext_gnt_i;
  logic              ext_rvalid_i;
  logic [31:0]       ext_rdata_i;

  modport master (
    input  swap_req_i, old_addr_idx_i, old_addr_i, new_addr_i,
    input  sram_rdata_i, ext_gnt_i, ext_rvalid_i, ext_rdata_i,
    output done_o, busy_o, sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o,
    output ext_req_o, ext_we_o, ext_addr_o, ext_wdata_o
  );

  modport slave (
    output swap_req_i, old_addr_idx_i, old_addr_i, new_addr_i,
    output sram_rdata_i, ext_gnt_i, ext_rvalid_i, ext_rdata_i,
    input  done_o, busy_o, sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o,
    input  ext_req_o, ext_we_o, ext_addr_o, ext_wdata_o
  );
endinterface

// File: rtl/block_swap_sequencer.sv
// Block swap sequencer: writes a victim SRAM block back to external memory word by word,
// then fetches the new block into the same slot. Outputs are registered from the next state.
module block_swap_sequencer #(
  parameter int unsigned BlockWords = 16,
  parameter int unsigned NumSlots   = 4,
  parameter logic [31:0] ExtBase    = 32'h8000_0000
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  block_swap_sequencer_if.master bus
);
  localparam int unsigned SlotW  = $clog2(NumSlots);
  localparam int unsigned WordW  = $clog2(BlockWords);
  localparam int unsigned SramAw = SlotW + WordW;
  localparam int unsigned AddrW  = 21;
  localparam logic [AddrW-1:0] EmptyAddr = '1;
  localparam logic [WordW-1:0] LastWord  = WordW'(BlockWords - 1);

  typedef enum logic [3:0] {
    IDLE, WB_RD, WB_CAP, WB_REQ, WB_RSP, FL_REQ, FL_RSP, FL_WR, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [SlotW-1:0]  slot_q, slot_d;
  logic [AddrW-1:0]  old_q, old_d;
  logic [AddrW-1:0]  new_q, new_d;
  logic [WordW-1:0]  cnt_q, cnt_d;
  logic [31:0]       data_q, data_d;

  logic              done_d, busy_d, sram_req_d, sram_we_d, ext_req_d, ext_we_d;
  logic [SramAw-1:0] sram_addr_d;
  logic [31:0]       sram_wdata_d, ext_addr_d, ext_wdata_d;

  function automatic logic [31:0] ext_byte_addr(input logic [AddrW-1:0] blk,
                                                input logic [WordW-1:0] word);
    return ExtBase + 32'({blk, word, 2'b00});
  endfunction

  // Next state plus the output values that the next state will present
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    old_d        = old_q;
    new_d        = new_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    done_d       = 1'b0;
    busy_d       = 1'b0;
    sram_req_d   = 1'b0;
    sram_we_d    = 1'b0;
    sram_addr_d  = '0;
    sram_wdata_d = '0;
    ext_req_d    = 1'b0;
    ext_we_d     = 1'b0;
    ext_addr_d   = '0;
    ext_wdata_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.swap_req_i) begin
          slot_d  = bus.old_addr_idx_i;
          old_d   = bus.old_addr_i;
          new_d   = bus.new_addr_i;
          cnt_d   = '0;
          state_d = (bus.old_addr_i == EmptyAddr) ? FL_REQ : WB_RD;
        end
      end
      WB_RD:  state_d = WB_CAP;
      WB_CAP: begin
        data_d  = bus.sram_rdata_i;
        state_d = WB_REQ;
      end
      WB_REQ: if (bus.ext_gnt_i) state_d = WB_RSP;
      WB_RSP: begin
        if (bus.ext_rvalid_i) begin
          if (cnt_q == LastWord) begin
            cnt_d   = '0;
            state_d = FL_REQ;
          end else begin
            cnt_d   = cnt_q + WordW'(1);
            state_d = WB_RD;
          end
        end
      end
      FL_REQ: if (bus.ext_gnt_i) state_d = FL_RSP;
      FL_RSP: begin
        if (bus.ext_rvalid_i) begin
          data_d  = bus.ext_rdata_i;
          state_d = FL_WR;
        end
      end
      FL_WR: begin
        if (cnt_q == LastWord) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + WordW'(1);
          state_d = FL_REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Request outputs depend only on held registers, so they stay stable while ungranted
    busy_d = (state_d != IDLE);
    unique case (state_d)
      WB_RD: begin
        sram_req_d  = 1'b1;
        sram_addr_d = {slot_d, cnt_d};
      end
      WB_REQ: begin
        ext_req_d   = 1'b1;
        ext_we_d    = 1'b1;
        ext_addr_d  = ext_byte_addr(old_d, cnt_d);
        ext_wdata_d = data_d;
      end
      FL_REQ: begin
        ext_req_d  = 1'b1;
        ext_addr_d = ext_byte_addr(new_d, cnt_d);
      end
      FL_WR: begin
        sram_req_d   = 1'b1;
        sram_we_d    = 1'b1;
        sram_addr_d  = {slot_d, cnt_d};
        sram_wdata_d = data_d;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      slot_q           <= '0;
      old_q            <= '0;
      new_q            <= '0;
      cnt_q            <= '0;
      data_q           <= '0;
      bus.done_o       <= 1'b0;
      bus.busy_o       <= 1'b0;
      bus.sram_req_o   <= 1'b0;
      bus.sram_we_o    <= 1'b0;
      bus.sram_addr_o  <= '0;
      bus.sram_wdata_o <= '0;
      bus.ext_req_o    <= 1'b0;
      bus.ext_we_o     <= 1'b0;
      bus.ext_addr_o   <= '0;
      bus.ext_wdata_o  <= '0;
    end else begin
      state_q          <= state_d;
      slot_q           <= slot_d;
      old_q            <= old_d;
      new_q            <= new_d;
      cnt_q            <= cnt_d;
      data_q           <= data_d;
      bus.done_o       <= done_d;
      bus.busy_o       <= busy_d;
      bus.sram_req_o   <= sram_req_d;
      bus.sram_we_o    <= sram_we_d;
      bus.sram_addr_o  <= sram_addr_d;
      bus.sram_wdata_o <= sram_wdata_d;
      bus.ext_req_o    <= ext_req_d;
      bus.ext_we_o     <= ext_we_d;
      bus.ext_addr_o   <= ext_addr_d;
      bus.ext_wdata_o  <= ext_wdata_d;
    end
  end
endmodule
